// File: rtl/nios2_pio_in_irq.sv
// -----------------------------------------------------------------------------
// nios2_pio_in_irq
//
// Avalon-MM input port for the NIOS2 data master. Up to 32 asynchronous pins
// pass through a per-pin synchroniser and a per-bit debounce filter. Accepted
// level changes of the configured polarity are recorded in a sticky
// edge-capture register. A maskable, active-high level interrupt is raised
// while any captured and enabled bit is set.
//
// Register map (word addresses, unused upper bits read 0):
//   0 DATA : filtered pin value (read-only)
//   1      : reserved (reads 0)
//   2 MASK : interrupt mask (read/write)
//   3 EDGE : edge capture (read; write 1 to clear a bit)
//
// Bus protocol: the slave has no wait states and no valid/ready handshake.
// A write is taken on any rising clk edge where chipselect=1 and write_n=0.
// readdata is reloaded on every edge from the register that address selects,
// so read data is valid the cycle after the address is presented. Reads have
// no side effects.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset_n    asynchronous active-low reset, clears all state
//   address    word address
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data (bits at WIDTH and above ignored)
//   in_port    asynchronous input pins
//   readdata   registered read data
//   irq        level interrupt, OR of (edge & mask)
// -----------------------------------------------------------------------------
module nios2_pio_in_irq #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Synchroniser chain: index 0 is the first flop, SYNC_STAGES-1 the output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync_s;

  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            filt_q;
  logic [WIDTH-1:0]            filt_d;
  logic [WIDTH-1:0]            update;
  logic [WIDTH-1:0]            edge_set;
  logic [WIDTH-1:0]            edge_clr;
  logic [WIDTH-1:0]            edge_q;
  logic [WIDTH-1:0]            edge_d;
  logic [WIDTH-1:0]            mask_q;
  logic [WIDTH-1:0]            mask_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      rd_d;

  assign wr_en   = chipselect & ~write_n;
  assign wr_bits = writedata[WIDTH-1:0];

  // Upper writedata bits are intentionally ignored for narrow ports.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, writedata};

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Debounce: a bit's counter runs only while the synchronised level
  // disagrees with the filtered level; any agreement restarts it. The change
  // is accepted on the edge where the counter has already seen
  // DEBOUNCE_CYCLES-1 disagreeing edges, i.e. the DEBOUNCE_CYCLES-th one.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync_s[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync_s[i];
        cnt_d[i]  = '0;
        update[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Edge qualification uses the new filtered value, so the capture bit sets
  // on the same edge that the filtered value changes.
  always_comb begin
    case (EDGE_TYPE)
      0:       edge_set = update & filt_d;
      1:       edge_set = update & ~filt_d;
      default: edge_set = update;
    endcase
  end

  // Set has priority over a simultaneous write-1-to-clear on the same bit.
  assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? wr_bits : '0;
  assign edge_d   = (edge_q & ~edge_clr) | edge_set;
  assign mask_d   = (wr_en && (address == ADDR_MASK)) ? wr_bits : mask_q;

  always_comb begin
    case (address)
      ADDR_DATA: rd_d = 32'(filt_q);
      ADDR_MASK: rd_d = 32'(mask_q);
      ADDR_EDGE: rd_d = 32'(edge_q);
      default:   rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      filt_q   <= '0;
      edge_q   <= '0;
      mask_q   <= '0;
      readdata <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], in_port};
      cnt_q    <= cnt_d;
      filt_q   <= filt_d;
      edge_q   <= edge_d;
      mask_q   <= mask_d;
      readdata <= rd_d;
    end
  end

  // Registers only: no combinational path from the pins or the bus to irq.
  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_nios2_pio_in_irq.sv
// -----------------------------------------------------------------------------
// Bench for nios2_pio_in_irq. Three instances share every input and differ
// only in EDGE_TYPE (0 rising, 1 falling, 2 any). A reference model describes
// the filter as "a bit takes the opposite level once every pin sample in the
// acceptance window disagrees with it", using a plain history of raw samples.
// -----------------------------------------------------------------------------
module tb_nios2_pio_in_irq;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int D  = 3;
  localparam int HN = S + D - 1;

  // Clock / reset
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DUT inputs (driven only just after falling edges)
  logic [1:0]   address    = 2'd0;
  logic         chipselect = 1'b0;
  logic         write_n    = 1'b1;
  logic [31:0]  writedata  = 32'h0;
  logic [W-1:0] in_port    = '0;

  logic [31:0] rd_dut [3];
  logic [2:0]  irq_dut;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nios2_pio_in_irq #(
      .WIDTH          (W),
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D),
      .EDGE_TYPE      (g)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .in_port   (in_port),
      .readdata  (rd_dut[g]),
      .irq       (irq_dut[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // hist_m[0] is the pin value sampled at the most recent edge. At edge n the
  // window is the samples taken at edges n-S-D+1 .. n-S (indices S-1..HN-1).
  // ---------------------------------------------------------------------------
  logic [HN-1:0][W-1:0] hist_m;
  logic [W-1:0]         f_m, nf_m, mask_m, nmask_m;
  logic [W-1:0]         edge_m [3];
  logic [W-1:0]         nedge_m [3];
  logic [31:0]          rd_m [3];
  logic [31:0]          nrd_m [3];
  logic [2:0]           irq_m;

  function automatic logic [W-1:0] model_f(input logic [W-1:0] f,
                                           input logic [HN-1:0][W-1:0] h);
    logic [W-1:0] r;
    int           dis;
    r = f;
    for (int i = 0; i < W; i++) begin
      dis = 0;
      for (int k = S - 1; k < HN; k++)
        if (h[k][i] != f[i]) dis++;
      if (dis == D) r[i] = ~f[i];
    end
    return r;
  endfunction

  always_comb begin
    logic         wr;
    logic [W-1:0] wd;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] clr;
    logic [W-1:0] set_k;
    wr    = chipselect && !write_n;
    wd    = writedata[W-1:0];
    nf_m  = model_f(f_m, hist_m);
    rise  = nf_m & ~f_m;
    fall  = ~nf_m & f_m;
    clr   = (wr && address == 2'd3) ? wd : '0;
    nmask_m = (wr && address == 2'd2) ? wd : mask_m;
    set_k = '0;
    for (int k = 0; k < 3; k++) begin
      set_k      = (k == 0) ? rise : (k == 1) ? fall : (rise | fall);
      nedge_m[k] = (edge_m[k] & ~clr) | set_k;
      case (address)
        2'd0:    nrd_m[k] = 32'(f_m);
        2'd2:    nrd_m[k] = 32'(mask_m);
        2'd3:    nrd_m[k] = 32'(edge_m[k]);
        default: nrd_m[k] = 32'h0;
      endcase
      irq_m[k] = |(edge_m[k] & mask_m);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_m <= '0;
      f_m    <= '0;
      mask_m <= '0;
      for (int k = 0; k < 3; k++) begin
        edge_m[k] <= '0;
        rd_m[k]   <= '0;
      end
    end else begin
      hist_m <= {hist_m[HN-2:0], in_port};
      f_m    <= nf_m;
      mask_m <= nmask_m;
      for (int k = 0; k < 3; k++) begin
        edge_m[k] <= nedge_m[k];
        rd_m[k]   <= nrd_m[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (called just after a falling edge, return after one)
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    logic [31:0] exp;
    in_port = 4'hF;
    address = 2'd0;
    reset_n = 1'b0;
    wait_cycles(3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_dut[k] !== 32'h0 || irq_dut[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_init dut%0d: readdata=%h irq=%b, expected 0/0", k, rd_dut[k], irq_dut[k]);
      end
    end
    // Release; pins high so f must rise after exactly S+D edges.
    reset_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c >= 5) begin
        exp = (c == 6) ? 32'hF : 32'h0;
        checks++;
        if (rd_dut[0] !== exp) begin
          errors++;
          $display("FAIL reset_release_data edge%0d: readdata=%h expected %h", c, rd_dut[0], exp);
        end
      end
    end
    address = 2'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp = (k == 1) ? 32'h0 : 32'hF;
      checks++;
      if (rd_dut[k] !== exp) begin
        errors++;
        $display("FAIL reset_release_edge dut%0d: readdata=%h expected %h", k, rd_dut[k], exp);
      end
    end
    // Mid-run reset with pending interrupt and nonzero readdata.
    bus_write(2'd2, 32'hF);
    address = 2'd0;
    @(negedge clk);
    checks++;
    if (irq_dut !== 3'b101) begin
      errors++;
      $display("FAIL reset_pre_irq: irq=%b expected 101", irq_dut);
    end
    #3 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_dut[k] !== 32'h0 || irq_dut[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_async dut%0d: readdata=%h irq=%b, expected 0/0", k, rd_dut[k], irq_dut[k]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_cycles(8);
  endtask

  task automatic test_debounce;
    in_port = 4'h0;
    wait_cycles(10);
    bus_write(2'd3, 32'hF);
    address = 2'd0;
    // 2-cycle pulse: must be rejected.
    in_port = 4'h1;
    wait_cycles(2);
    in_port = 4'h0;
    wait_cycles(8);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_dut[k] !== 32'h0) begin
        errors++;
        $display("FAIL debounce_short_data dut%0d: readdata=%h expected 0", k, rd_dut[k]);
      end
    end
    address = 2'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_dut[k] !== 32'h0) begin
        errors++;
        $display("FAIL debounce_short_edge dut%0d: readdata=%h expected 0", k, rd_dut[k]);
      end
    end
    // 3-cycle pulse: f[0] rises 5 edges after the pulse starts.
    address = 2'd0;
    in_port = 4'h1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5 || c == 6) begin
        checks++;
        if (rd_dut[0][0] !== (c == 6)) begin
          errors++;
          $display("FAIL debounce_long_data edge%0d: bit0=%b expected %b", c, rd_dut[0][0], (c == 6));
        end
      end
      if (c == 3) in_port = 4'h0;
    end
    address = 2'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_dut[k] !== 32'h1) begin
        errors++;
        $display("FAIL debounce_long_edge dut%0d: readdata=%h expected 1", k, rd_dut[k]);
      end
    end
  endtask

  task automatic test_irq;
    in_port = 4'h0;
    wait_cycles(10);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h1);
    in_port = 4'h1;
    wait_cycles(8);
    checks++;
    if (irq_dut !== 3'b101) begin
      errors++;
      $display("FAIL irq_set: irq=%b expected 101", irq_dut);
    end
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq_dut !== 3'b000) begin
      errors++;
      $display("FAIL irq_clear: irq=%b expected 000", irq_dut);
    end
    in_port = 4'h3;
    wait_cycles(8);
    checks++;
    if (irq_dut !== 3'b000) begin
      errors++;
      $display("FAIL irq_masked: irq=%b expected 000", irq_dut);
    end
    address = 2'd3;
    @(negedge clk);
    checks++;
    if (rd_dut[0] !== 32'h2) begin
      errors++;
      $display("FAIL irq_masked_edge: readdata=%h expected 2", rd_dut[0]);
    end
  endtask

  task automatic test_collision;
    logic [31:0] exp;
    in_port = 4'h0;
    wait_cycles(10);
    bus_write(2'd3, 32'hF);
    in_port = 4'h4;
    wait_cycles(4);
    // Write lands on the 5th edge, the same edge as the bit-2 update.
    bus_write(2'd3, 32'hF);
    address = 2'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp = (k == 1) ? 32'h0 : 32'h4;
      checks++;
      if (rd_dut[k] !== exp) begin
        errors++;
        $display("FAIL collision dut%0d: readdata=%h expected %h", k, rd_dut[k], exp);
      end
    end
  endtask

  task automatic test_modes;
    logic [31:0] exp;
    in_port = 4'hF;
    wait_cycles(10);
    bus_write(2'd3, 32'hF);
    in_port = 4'h0;
    wait_cycles(10);
    address = 2'd3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      exp = (k == 0) ? 32'h0 : 32'hF;
      checks++;
      if (rd_dut[k] !== exp) begin
        errors++;
        $display("FAIL modes_fall dut%0d: readdata=%h expected %h", k, rd_dut[k], exp);
      end
    end
    bus_write(2'd3, 32'hF);
    in_port = 4'h8;
    wait_cycles(10);
    address = 2'd3;
    @(negedge clk);
    checks++;
    if (rd_dut[2] !== 32'h8) begin
      errors++;
      $display("FAIL modes_any_rise: readdata=%h expected 8", rd_dut[2]);
    end
    bus_write(2'd3, 32'hF);
    in_port = 4'h0;
    wait_cycles(10);
    address = 2'd3;
    @(negedge clk);
    checks++;
    if (rd_dut[2] !== 32'h8) begin
      errors++;
      $display("FAIL modes_any_fall: readdata=%h expected 8", rd_dut[2]);
    end
  endtask

  task automatic test_bus;
    bus_write(2'd0, 32'hF);
    bus_write(2'd1, 32'hF);
    address = 2'd0;
    @(negedge clk);
    checks++;
    if (rd_dut[0] !== 32'h0) begin
      errors++;
      $display("FAIL bus_data_ro: readdata=%h expected 0", rd_dut[0]);
    end
    address = 2'd1;
    @(negedge clk);
    checks++;
    if (rd_dut[0] !== 32'h0) begin
      errors++;
      $display("FAIL bus_reserved: readdata=%h expected 0", rd_dut[0]);
    end
    bus_write(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rd_dut[k] !== 32'h0000_000F) begin
        errors++;
        $display("FAIL bus_mask_rb dut%0d: readdata=%h expected 0000000f", k, rd_dut[k]);
      end
    end
    address = 2'd1;
    @(negedge clk);
    checks++;
    if (rd_dut[1] !== 32'h0) begin
      errors++;
      $display("FAIL bus_reserved2: readdata=%h expected 0", rd_dut[1]);
    end
  endtask

  task automatic test_random;
    int hold_left;
    hold_left = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (rd_dut[k] !== rd_m[k]) begin
          errors++;
          $display("FAIL rand_rd cyc%0d dut%0d: readdata=%h expected %h", c, k, rd_dut[k], rd_m[k]);
        end
        checks++;
        if (irq_dut[k] !== irq_m[k]) begin
          errors++;
          $display("FAIL rand_irq cyc%0d dut%0d: irq=%b expected %b", c, k, irq_dut[k], irq_m[k]);
        end
      end
      if (hold_left == 0) begin
        in_port   = W'($urandom);
        hold_left = $urandom_range(1, 8);
      end else begin
        hold_left--;
      end
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      if ($urandom_range(0, 199) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_irq();
    test_collision();
    test_modes();
    test_bus();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
